// File: rtl/ad936x_buffered_data_interface.sv
// AD936x single-data-rate sample bridge: chip-side I/Q framing to and from buffered baseband streams.
// Latency: RX pair visible one cycle after its Q phase edge; TX pops at the edge that starts an I phase.
// Backpressure: RX drops on a full FIFO (sticky overflow); TX ready = FIFO not full; an empty TX FIFO at an I edge sends zeros (sticky underflow). Counters: AD936X_STATUS_COUNTERS_EN.

module ad936x_bdi_fifo #(
  parameter int W     = 24,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] push_dat_i,
  input  logic         pop_i,
  output logic [W-1:0] pop_dat_o,
  output logic         empty_o,
  output logic         full_o
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   cnt_q;
  logic          do_push, do_pop;

  // Full is judged before any same-cycle pop, so a pop never frees room for that cycle's push.
  assign full_o    = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o   = (cnt_q == '0);
  assign do_push   = push_i & ~full_o;
  assign do_pop    = pop_i & ~empty_o;
  assign pop_dat_o = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

module ad936x_buffered_data_interface #(
  parameter int SAMPLE_WIDTH  = 12,
  parameter int RX_FIFO_DEPTH = 8,
  parameter int TX_FIFO_DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic [SAMPLE_WIDTH-1:0] bbp_rx_data_i,
  output logic [SAMPLE_WIDTH-1:0] bbp_rx_data_q,
  output logic                    bbp_rx_data_valid,
  input  logic                    bbp_rx_data_ready,
  input  logic [SAMPLE_WIDTH-1:0] bbp_tx_data_i,
  input  logic [SAMPLE_WIDTH-1:0] bbp_tx_data_q,
  input  logic                    bbp_tx_data_valid,
  output logic                    bbp_tx_data_ready,
  input  logic [SAMPLE_WIDTH-1:0] ad936x_rx_data,
  input  logic                    ad936x_rx_frame,
  input  logic                    ad936x_data_clk,
  output logic                    ad936x_data_clk_fb,
  output logic [SAMPLE_WIDTH-1:0] ad936x_tx_data,
  output logic                    ad936x_tx_frame,
  output logic                    rx_overflow,
  output logic                    tx_underflow,
  output logic [15:0]             rx_overflow_count,
  output logic [15:0]             tx_underflow_count,
  input  logic                    stat_clear
);
  localparam int W = SAMPLE_WIDTH;

  logic [W-1:0]   rx_data_d_q, rx_data_d2_q, rx_held_i_q;
  logic           rx_frame_d_q, rx_frame_d2_q, rx_i_held_q;
  logic           data_clk_d_q, data_clk_d2_q, data_clk_d3_q;
  logic           edge_e, rx_push, rx_empty, rx_full, rx_pop, rx_ovf_evt;
  logic [2*W-1:0] rx_head, tx_head;
  logic           tx_push, tx_pop, tx_empty, tx_full, tx_unf_evt;
  logic [W-1:0]   tx_data_q, tx_data_d, tx_held_q, tx_held_d;
  logic           tx_frame_q, tx_frame_d, rx_ovf_q, tx_unf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data_d_q   <= '0;
      rx_data_d2_q  <= '0;
      rx_frame_d_q  <= 1'b0;
      rx_frame_d2_q <= 1'b0;
      data_clk_d_q  <= 1'b0;
      data_clk_d2_q <= 1'b0;
      data_clk_d3_q <= 1'b0;
    end else begin
      rx_data_d_q   <= ad936x_rx_data;
      rx_data_d2_q  <= rx_data_d_q;
      rx_frame_d_q  <= ad936x_rx_frame;
      rx_frame_d2_q <= rx_frame_d_q;
      data_clk_d_q  <= ad936x_data_clk;
      data_clk_d2_q <= data_clk_d_q;
      data_clk_d3_q <= data_clk_d2_q;
    end
  end

  assign edge_e             = data_clk_d2_q & ~data_clk_d3_q;
  assign ad936x_data_clk_fb = data_clk_d2_q;

  // A Q phase without a preceding I is an orphan and is discarded.
  assign rx_push    = edge_e & ~rx_frame_d2_q & rx_i_held_q;
  assign rx_ovf_evt = rx_push & rx_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_held_i_q <= '0;
      rx_i_held_q <= 1'b0;
    end else if (edge_e) begin
      if (rx_frame_d2_q) begin
        rx_held_i_q <= rx_data_d2_q;
        rx_i_held_q <= 1'b1;
      end else begin
        rx_i_held_q <= 1'b0;
      end
    end
  end

  ad936x_bdi_fifo #(.W(2*W), .DEPTH(RX_FIFO_DEPTH)) u_rx_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (rx_push),
    .push_dat_i ({rx_held_i_q, rx_data_d2_q}),
    .pop_i      (rx_pop),
    .pop_dat_o  (rx_head),
    .empty_o    (rx_empty),
    .full_o     (rx_full)
  );

  assign bbp_rx_data_valid = ~rx_empty & ~rst;
  assign rx_pop            = bbp_rx_data_valid & bbp_rx_data_ready;
  assign bbp_rx_data_i     = bbp_rx_data_valid ? rx_head[2*W-1:W] : '0;
  assign bbp_rx_data_q     = bbp_rx_data_valid ? rx_head[W-1:0]   : '0;

  assign bbp_tx_data_ready = ~tx_full & ~rst;
  assign tx_push           = bbp_tx_data_valid & bbp_tx_data_ready;
  assign tx_pop            = edge_e & ~tx_frame_q & ~tx_empty;
  assign tx_unf_evt        = edge_e & ~tx_frame_q & tx_empty;

  ad936x_bdi_fifo #(.W(2*W), .DEPTH(TX_FIFO_DEPTH)) u_tx_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (tx_push),
    .push_dat_i ({bbp_tx_data_i, bbp_tx_data_q}),
    .pop_i      (tx_pop),
    .pop_dat_o  (tx_head),
    .empty_o    (tx_empty),
    .full_o     (tx_full)
  );

  always_comb begin
    tx_frame_d = tx_frame_q;
    tx_data_d  = tx_data_q;
    tx_held_d  = tx_held_q;
    if (edge_e) begin
      if (!tx_frame_q) begin
        tx_frame_d = 1'b1;
        if (!tx_empty) begin
          tx_data_d = tx_head[2*W-1:W];
          tx_held_d = tx_head[W-1:0];
        end else begin
          tx_data_d = '0;
          tx_held_d = '0;
        end
      end else begin
        tx_frame_d = 1'b0;
        tx_data_d  = tx_held_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_frame_q <= 1'b0;
      tx_data_q  <= '0;
      tx_held_q  <= '0;
    end else begin
      tx_frame_q <= tx_frame_d;
      tx_data_q  <= tx_data_d;
      tx_held_q  <= tx_held_d;
    end
  end

  assign ad936x_tx_data  = tx_data_q;
  assign ad936x_tx_frame = tx_frame_q;

  always_ff @(posedge clk) begin
    if (rst || stat_clear) begin
      rx_ovf_q <= 1'b0;
      tx_unf_q <= 1'b0;
    end else begin
      if (rx_ovf_evt) rx_ovf_q <= 1'b1;
      if (tx_unf_evt) tx_unf_q <= 1'b1;
    end
  end

  assign rx_overflow  = rx_ovf_q;
  assign tx_underflow = tx_unf_q;

`ifdef AD936X_STATUS_COUNTERS_EN
  logic [15:0] rx_ovf_cnt_q, tx_unf_cnt_q;

  always_ff @(posedge clk) begin
    if (rst || stat_clear) begin
      rx_ovf_cnt_q <= '0;
      tx_unf_cnt_q <= '0;
    end else begin
      if (rx_ovf_evt && rx_ovf_cnt_q != 16'hFFFF) rx_ovf_cnt_q <= rx_ovf_cnt_q + 16'd1;
      if (tx_unf_evt && tx_unf_cnt_q != 16'hFFFF) tx_unf_cnt_q <= tx_unf_cnt_q + 16'd1;
    end
  end

  assign rx_overflow_count  = rx_ovf_cnt_q;
  assign tx_underflow_count = tx_unf_cnt_q;
`else
  assign rx_overflow_count  = '0;
  assign tx_underflow_count = '0;
`endif
endmodule
